// File: rtl/sort_floats_seq.sv
// Sequential bubble sort of N floats around one shared f_less_or_equal.
// Define SORT_FLOATS_SEQ_EARLY_EXIT_EN to stop sorting after a pass with no swap.

package cvw_cfg;
   localparam int FLEN = 64;
endpackage

module f_less_or_equal
   import cvw_cfg::*;
(
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output logic            res,
   output logic            err
);

   localparam int NE = (FLEN == 128) ? 15 :
                       (FLEN == 64)  ? 11 :
                       (FLEN == 32)  ? 8  : 5;
   localparam int NM = FLEN - NE - 1;

   logic          a_sgn, b_sgn;
   logic [NE-1:0] a_exp, b_exp;
   logic [NM-1:0] a_man, b_man;
   logic          a_nan, b_nan, both_zero;
   logic          mag_le, mag_ge;

   assign a_sgn = a[FLEN-1];
   assign b_sgn = b[FLEN-1];
   assign a_exp = a[FLEN-2 -: NE];
   assign b_exp = b[FLEN-2 -: NE];
   assign a_man = a[NM-1:0];
   assign b_man = b[NM-1:0];

   assign a_nan = (&a_exp) && (|a_man);
   assign b_nan = (&b_exp) && (|b_man);
   assign both_zero = (a[FLEN-2:0] == '0) && (b[FLEN-2:0] == '0);

   // exponent:mantissa orders like an unsigned magnitude
   assign mag_le = a[FLEN-2:0] <= b[FLEN-2:0];
   assign mag_ge = a[FLEN-2:0] >= b[FLEN-2:0];

   assign err = a_nan || b_nan;

   always_comb begin
      res = 1'b0;
      if (err)
         res = 1'b0;
      else if (both_zero)
         res = 1'b1;
      else if (a_sgn != b_sgn)
         res = a_sgn;
      else if (!a_sgn)
         res = mag_le;
      else
         res = mag_ge;
   end

endmodule

module sort_floats_seq
   import cvw_cfg::*;
#(
   parameter int N = 4
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            up_valid,
   input  logic [FLEN-1:0] up_data,
   output logic            up_ready,
   output logic            down_valid,
   output logic [FLEN-1:0] down_data,
   output logic            down_last,
   output logic            down_err,
   input  logic            down_ready,
   output logic            busy
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      DRAIN
   } state_t;

   state_t state_q, state_d;

   logic [IW-1:0]   load_cnt;
   logic [IW-1:0]   pass_cnt;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   out_cnt;
   logic            err_q;
   logic [FLEN-1:0] mem [N];

   logic [FLEN-1:0] cmp_a, cmp_b;
   logic            cmp_res, cmp_err;
   logic            swap, pass_end, sort_done;
   logic            up_fire, down_fire;
   logic            load_last, drain_last;

   assign cmp_a = mem[idx];
   assign cmp_b = mem[idx + IW'(1)];

   f_less_or_equal u_cmp (
      .a   (cmp_a),
      .b   (cmp_b),
      .res (cmp_res),
      .err (cmp_err)
   );

   assign up_ready   = (state_q == LOAD);
   assign busy       = (state_q != LOAD);
   assign down_valid = (state_q == DRAIN);
   assign down_data  = down_valid ? mem[out_cnt] : '0;
   assign down_last  = down_valid && (out_cnt == LAST);
   assign down_err   = down_valid && err_q;

   assign up_fire    = up_valid && up_ready;
   assign down_fire  = down_valid && down_ready;
   assign load_last  = up_fire && (load_cnt == LAST);
   assign drain_last = down_fire && (out_cnt == LAST);

   // a NaN compare reports err with res=0, so it never swaps
   assign swap     = (state_q == SORT) && !cmp_res && !cmp_err;
   assign pass_end = (idx == LAST_PASS - pass_cnt);

`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
   logic swapped_q;

   assign sort_done = pass_end &&
                      ((pass_cnt == LAST_PASS) || !(swapped_q || swap));

   always_ff @(posedge clk) begin
      if (!rst_n)
         swapped_q <= 1'b0;
      else if (state_q == SORT) begin
         if (pass_end)
            swapped_q <= 1'b0;
         else if (swap)
            swapped_q <= 1'b1;
      end
   end
`else
   assign sort_done = pass_end && (pass_cnt == LAST_PASS);
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (load_last) state_d = SORT;
         SORT:    if (sort_done) state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= LOAD;
         load_cnt <= '0;
         pass_cnt <= '0;
         idx      <= '0;
         out_cnt  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (up_fire)
            load_cnt <= load_last ? '0 : load_cnt + IW'(1);
         if (state_q == SORT) begin
            err_q <= err_q | cmp_err;
            if (pass_end) begin
               idx      <= '0;
               pass_cnt <= sort_done ? '0 : pass_cnt + IW'(1);
            end else begin
               idx <= idx + IW'(1);
            end
         end
         if (down_fire) begin
            out_cnt <= drain_last ? '0 : out_cnt + IW'(1);
            if (drain_last)
               err_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (up_fire)
         mem[load_cnt] <= up_data;
      else if (swap) begin
         mem[idx]          <= cmp_b;
         mem[idx + IW'(1)] <= cmp_a;
      end
   end

endmodule
